// File: rtl/mux_operand_scheduler_if.sv
// Request/grant and operand-select bundle between the requesters and the
// operand scheduler that steers Mux_A/Mux_B and the rC accumulator.
interface mux_operand_scheduler_if #(
    parameter int LEN_W = 4
);
    logic             wReq0;
    logic [LEN_W-1:0] wLen0;
    logic [1:0]       wMode0;
    logic             wReq1;
    logic [LEN_W-1:0] wLen1;
    logic [1:0]       wMode1;
    logic             wStall;
    logic             rGnt0;
    logic             rGnt1;
    logic             rMux_a_sel;
    logic             rMux_b_sel;
    logic             rLoad_C;
    logic             rDone;
    logic             rOwner;

    modport master (
        output wReq0, wLen0, wMode0,
        output wReq1, wLen1, wMode1,
        output wStall,
        input  rGnt0, rGnt1,
        input  rMux_a_sel, rMux_b_sel,
        input  rLoad_C, rDone, rOwner
    );

    modport slave (
        input  wReq0, wLen0, wMode0,
        input  wReq1, wLen1, wMode1,
        input  wStall,
        output rGnt0, rGnt1,
        output rMux_a_sel, rMux_b_sel,
        output rLoad_C, rDone, rOwner
    );
endinterface

// File: rtl/mux_operand_scheduler.sv
// Round-robin burst scheduler for the shared Mux_A/Mux_B operand path;
// drives the rC feedback selects and accumulator load beat by beat.
module mux_operand_scheduler #(
    parameter int LEN_W = 4
) (
    input  logic                    Clock,
    input  logic                    Reset,
    mux_operand_scheduler_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] cnt_nx;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] len_nx;
    logic [LEN_W-1:0] len_m1;
    logic [1:0]       mode;
    logic [1:0]       mode_nx;
    logic             owner;
    logic             owner_nx;
    logic             pick;
    logic             run;
    logic             first;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            cnt   <= '0;
            len   <= '0;
            mode  <= '0;
            owner <= 1'b1;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            len   <= len_nx;
            mode  <= mode_nx;
            owner <= owner_nx;
        end
    end

    // Length 0 wraps to all-ones here, giving 2^LEN_W beats.
    assign len_m1 = len - LEN_W'(1);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        len_nx   = len;
        mode_nx  = mode;
        owner_nx = owner;
        pick     = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.wReq0 || bus.wReq1) begin
                    if (bus.wReq0 && bus.wReq1)
                        pick = ~owner;
                    else
                        pick = bus.wReq1;
                    owner_nx = pick;
                    len_nx   = pick ? bus.wLen1 : bus.wLen0;
                    mode_nx  = pick ? bus.wMode1 : bus.wMode0;
                    cnt_nx   = '0;
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (!bus.wStall) begin
                    if (cnt == len_m1)
                        state_nx = DONE;
                    else
                        cnt_nx = cnt + LEN_W'(1);
                end
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Beat 0 always takes the external operands; rC only from beat 1 on.
    assign run   = (state == RUN);
    assign first = (cnt == '0);

    assign bus.rGnt0      = run & ~owner;
    assign bus.rGnt1      = run & owner;
    assign bus.rLoad_C    = run & ~bus.wStall;
    assign bus.rMux_a_sel = run & mode[0] & ~first;
    assign bus.rMux_b_sel = run & mode[1] & ~first;
    assign bus.rDone      = (state == DONE);
    assign bus.rOwner     = owner;
endmodule

// File: tb/tb_mux_operand_scheduler.sv
// Scoreboard bench: stimulus queues expected beats/done pulses, a
// negedge monitor pops and compares whenever load or done is shown.
module tb_mux_operand_scheduler;
    logic Clock;
    logic Reset;

    mux_operand_scheduler_if #(.LEN_W(4)) bus ();

    mux_operand_scheduler #(.LEN_W(4)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic done;
        logic idx;
        logic a;
        logic b;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic push_burst(input logic idx, input int n,
                              input logic [1:0] m, input int keep);
        exp_t e;
        for (int i = 0; i < keep; i++) begin
            e.done = 1'b0;
            e.idx  = idx;
            e.a    = m[0] && (i != 0);
            e.b    = m[1] && (i != 0);
            q.push_back(e);
        end
        if (keep == n) begin
            e.done = 1'b1;
            e.idx  = idx;
            e.a    = 1'b0;
            e.b    = 1'b0;
            q.push_back(e);
        end
    endtask

    task automatic wait_gnt(input logic idx);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(posedge Clock);
            #1;
            if (idx ? bus.rGnt1 : bus.rGnt0)
                ok = 1'b1;
        end
        check("gnt_wait", ok, 1);
    endtask

    task automatic wait_done(output int cyc);
        bit ok;
        ok  = 1'b0;
        cyc = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(posedge Clock);
            #1;
            cyc++;
            if (bus.rDone)
                ok = 1'b1;
        end
        check("done_wait", ok, 1);
    endtask

    task automatic drive(input logic idx, input logic req,
                         input logic [3:0] len, input logic [1:0] m);
        if (idx) begin
            bus.wReq1  = req;
            bus.wLen1  = len;
            bus.wMode1 = m;
        end else begin
            bus.wReq0  = req;
            bus.wLen0  = len;
            bus.wMode0 = m;
        end
    endtask

    task automatic run_burst(input logic idx, input logic [3:0] len,
                             input logic [1:0] m, input int beats);
        int cyc;
        push_burst(idx, beats, m, beats);
        drive(idx, 1'b1, len, m);
        wait_gnt(idx);
        drive(idx, 1'b0, len, m);
        wait_done(cyc);
        check("burst_cycles", cyc, beats);
        @(posedge Clock);
        #1;
    endtask

    always @(negedge Clock) begin
        exp_t       e;
        logic [1:0] eg;
        check("gnt_excl", bus.rGnt0 & bus.rGnt1, 0);
        if (bus.rLoad_C || bus.rDone) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out load=%0b done=%0b t=%0t",
                         bus.rLoad_C, bus.rDone, $time);
            end else begin
                e  = q.pop_front();
                eg = e.done ? 2'b00 : (e.idx ? 2'b10 : 2'b01);
                check("kind", bus.rDone, e.done);
                check("owner", bus.rOwner, e.idx);
                check("gnt", {bus.rGnt1, bus.rGnt0}, eg);
                check("a_sel", bus.rMux_a_sel, e.a);
                check("b_sel", bus.rMux_b_sel, e.b);
            end
        end
    end

    initial begin
        int cyc;
        int dones;
        Reset      = 1'b1;
        bus.wStall = 1'b0;
        drive(1'b0, 1'b0, 4'd0, 2'b00);
        drive(1'b1, 1'b0, 4'd0, 2'b00);
        #12;
        check("rst_gnt", {bus.rGnt1, bus.rGnt0}, 0);
        check("rst_load", bus.rLoad_C, 0);
        check("rst_done", bus.rDone, 0);
        check("rst_sel", {bus.rMux_a_sel, bus.rMux_b_sel}, 0);
        check("rst_owner", bus.rOwner, 1);
        @(posedge Clock);
        #1;
        Reset = 1'b0;

        // 1: three beats, rC onto operand A from beat 1
        run_burst(1'b0, 4'd3, 2'b01, 3);
        check("idle_after1", {bus.rGnt1, bus.rGnt0, bus.rDone}, 0);

        // 2: both requesting, len 1, alternate starting at 0
        Reset = 1'b1;
        #2;
        Reset = 1'b0;
        check("owner_rst2", bus.rOwner, 1);
        push_burst(1'b0, 1, 2'b01, 1);
        push_burst(1'b1, 1, 2'b10, 1);
        push_burst(1'b0, 1, 2'b01, 1);
        push_burst(1'b1, 1, 2'b10, 1);
        drive(1'b0, 1'b1, 4'd1, 2'b01);
        drive(1'b1, 1'b1, 4'd1, 2'b10);
        dones = 0;
        for (int i = 0; i < 40 && dones < 4; i++) begin
            @(posedge Clock);
            #1;
            if (bus.rDone)
                dones++;
        end
        drive(1'b0, 1'b0, 4'd1, 2'b01);
        drive(1'b1, 1'b0, 4'd1, 2'b10);
        check("rr_dones", dones, 4);
        repeat (3) @(posedge Clock);
        #1;

        // 3: requester 1, two beats, stall two cycles before beat 1
        push_burst(1'b1, 2, 2'b11, 2);
        drive(1'b1, 1'b1, 4'd2, 2'b11);
        wait_gnt(1'b1);
        drive(1'b1, 1'b0, 4'd2, 2'b11);
        @(posedge Clock);
        #1;
        bus.wStall = 1'b1;
        #1;
        check("stall_load0", bus.rLoad_C, 0);
        check("stall_bsel0", bus.rMux_b_sel, 1);
        @(posedge Clock);
        #1;
        check("stall_load1", bus.rLoad_C, 0);
        check("stall_bsel1", bus.rMux_b_sel, 1);
        check("stall_gnt1", bus.rGnt1, 1);
        check("stall_done1", bus.rDone, 0);
        @(posedge Clock);
        #1;
        bus.wStall = 1'b0;
        wait_done(cyc);
        check("stall_tail", cyc, 1);
        @(posedge Clock);
        #1;

        // 4: length 0 means 16 beats
        run_burst(1'b0, 4'd0, 2'b11, 16);

        // 5: async reset on beat 2 of a 5-beat burst
        push_burst(1'b0, 5, 2'b11, 2);
        drive(1'b0, 1'b1, 4'd5, 2'b11);
        wait_gnt(1'b0);
        drive(1'b0, 1'b0, 4'd5, 2'b11);
        @(posedge Clock);
        #1;
        @(posedge Clock);
        #1;
        check("beat2_load", bus.rLoad_C, 1);
        Reset = 1'b1;
        #1;
        check("abort_gnt", {bus.rGnt1, bus.rGnt0}, 0);
        check("abort_sel", {bus.rMux_a_sel, bus.rMux_b_sel}, 0);
        check("abort_ld", {bus.rLoad_C, bus.rDone}, 0);
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        run_burst(1'b1, 4'd2, 2'b10, 2);

        // 6: drop request and change length mid-burst
        push_burst(1'b0, 4, 2'b10, 4);
        drive(1'b0, 1'b1, 4'd4, 2'b10);
        wait_gnt(1'b0);
        drive(1'b0, 1'b0, 4'd7, 2'b10);
        wait_done(cyc);
        check("chg_cycles", cyc, 4);
        for (int i = 0; i < 5; i++) begin
            @(posedge Clock);
            #1;
            check("no_regrant", bus.rGnt0, 0);
        end

        check("queue_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mux_operand_scheduler.md
Name: mux_operand_scheduler

Overview:
- Control block for the shared operand path built from two `Mux2` instances (Mux_A, Mux_B) that feed the ALU, with accumulator `rC` fed back on the B inputs.
- Arbitrates two requesters for bursts of datapath beats using round-robin.
- For the granted requester it drives `rMux_a_sel`, `rMux_b_sel` and the accumulator load enable beat by beat.
- Reports burst completion with a one-cycle done pulse.

Parameters:
- LEN_W, 4, width of the burst-length inputs and of the internal beat counter.

Ports:
- Clock  input  1  single system clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-high; clears all state immediately.
- wReq0  input  1  requester 0 wants a burst.
- wLen0  input  LEN_W  requester 0 beat count; 0 means 2^LEN_W beats.
- wMode0  input  2  requester 0 feedback mode; bit0 feeds `rC` to operand A, bit1 feeds `rC` to operand B.
- wReq1  input  1  requester 1 wants a burst.
- wLen1  input  LEN_W  requester 1 beat count.
- wMode1  input  2  requester 1 feedback mode.
- wStall  input  1  datapath stall; a cycle with wStall=1 is not a beat.
- rGnt0  output  1  requester 0 owns the datapath.
- rGnt1  output  1  requester 1 owns the datapath.
- rMux_a_sel  output  1  drives Mux_A `wSelect` (1 selects `rC`).
- rMux_b_sel  output  1  drives Mux_B `wSelect` (1 selects `rC`).
- rLoad_C  output  1  accumulator write enable for the current beat.
- rDone  output  1  one-cycle pulse after the last beat of a burst.
- rOwner  output  1  index of the requester most recently granted.

Behaviour:
- Reset values (asynchronous):
  - state = IDLE.
  - rGnt0 = rGnt1 = rDone = rLoad_C = rMux_a_sel = rMux_b_sel = 0.
  - Beat counter = 0.
  - rOwner = 1, so requester 0 wins the first tie.
  - Latched length and mode = 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - Requests are sampled at each edge.
  - Only one request active: grant it.
  - Both active: grant the requester that is not rOwner.
  - On grant:
    - Latch that requester's wLen and wMode.
    - Set the matching rGntN=1 and rOwner=N.
    - Clear the counter.
    - Go to RUN.
  - No request: stay in IDLE, all outputs 0.
- RUN:
  - A beat is any cycle with wStall=0.
  - rLoad_C = RUN & !wStall (combinational from registered state and wStall).
  - Beat index = counter value.
  - rMux_a_sel = RUN & mode[0] & (counter != 0).
  - rMux_b_sel = RUN & mode[1] & (counter != 0).
  - Beat 0 therefore always takes external operands.
  - Mux selects are decoded from registered state only and do not depend on wStall.
  - On a beat where counter == latched_len - 1 (LEN_W-bit wrap, so len 0 gives 2^LEN_W beats):
    - Go to DONE.
    - Clear the grant.
    - Set rDone=1.
  - Otherwise the counter increments on each beat.
  - While stalled, the counter, grant and selects hold.
- DONE:
  - rDone=1 for exactly this cycle, then go to IDLE.
  - Gap between consecutive grants is at least 2 cycles: one in DONE, then one in IDLE for sampling.
- Request handling:
  - wReq and wLen/wMode changes during RUN or DONE are ignored; the burst always completes.
  - Requesters must hold inputs stable until their grant appears.
- rGnt0 and rGnt1 are never high together.
- Reset during RUN aborts the burst: grant, selects and load drop immediately, with no rDone.

Test Plan:
1. Reset, then wReq0=1 with wLen0=3, wMode0=01, no stall.
   - Grant sampled at edge k; rGnt0=1 after k.
   - rLoad_C=1 for the 3 cycles after k.
   - rMux_a_sel=0,1,1; rMux_b_sel=0,0,0.
   - rDone=1 in the cycle after k+3; IDLE after k+4.
2. wReq0 and wReq1 both held high with len=1.
   - Grants alternate 0,1,0,1.
   - rOwner toggles; rGnt0 and rGnt1 never high together.
3. wReq1=1, wLen1=2, wMode1=11, wStall=1 for 2 cycles mid-burst.
   - rLoad_C=0 and counter frozen during the stall.
   - The burst still delivers exactly 2 beats; rMux_b_sel=1 on beat 1.
4. wLen0=0.
   - Exactly 16 beats, then rDone.
5. Reset asserted asynchronously on beat 2 of a 5-beat burst.
   - All outputs 0 before the next edge; rDone never pulses.
   - After reset release with wReq1=1, requester 1 is granted next.
6. wReq0 dropped, and wLen0 changed to 7, during RUN of a 4-beat burst.
   - Still exactly 4 beats plus rDone.
   - No new grant to requester 0 afterwards.
